// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and types for the UART command sequencer: header byte,
// opcodes, FSM states and error codes.
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] HDR_BYTE  = 8'h55;
   localparam logic [7:0] OP_THR_HI = 8'h01;
   localparam logic [7:0] OP_THR_LO = 8'h02;
   localparam logic [7:0] OP_PERIOD = 8'h03;
   localparam logic [7:0] OP_RPT_EN = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OP,
      ST_D1,
      ST_D0,
      ST_CHK
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_TIMEOUT  = 2'b01,
      ERR_OPCODE   = 2'b10,
      ERR_CHECKSUM = 2'b11
   } err_t;

   function automatic logic op_legal(input logic [7:0] op);
      return (op == OP_THR_HI) || (op == OP_THR_LO) ||
             (op == OP_PERIOD) || (op == OP_RPT_EN);
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Received-byte stream from uart_rx into the command sequencer.
interface uart_cmd_ctrl_if;

   logic [7:0] din;
   logic       din_vld;

   modport master (output din, output din_vld);
   modport slave  (input  din, input  din_vld);

endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: cleared by clr, counts while run, and flags
// expire on the last allowed cycle unless a clear arrives that same cycle.
module uart_cmd_timer #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   // A byte arriving on the expiry cycle wins over the timeout.
   assign expire = run && !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !run || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: assembles 0x55-headed frames from uart_rx bytes and writes
// the monitor configuration registers. UART_CMD_CHECKSUM_EN adds a CHK byte.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int          TIMEOUT_CYC = 100000,
   parameter logic [15:0] THR_HI_RST  = 16'h0320,
   parameter logic [15:0] THR_LO_RST  = 16'h0000,
   parameter logic [15:0] PERIOD_RST  = 16'd1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_cmd_ctrl_if.slave        rx,
   output logic [15:0]           thr_hi,
   output logic [15:0]           thr_lo,
   output logic [15:0]           period,
   output logic                  rpt_en,
   output logic                  cmd_ok,
   output logic                  cmd_err,
   output logic [1:0]            err_code
);

   state_t      state;
   logic [7:0]  op;
   logic [7:0]  d1;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]  d0;
`endif
   logic        expire;
   logic        frame_end;
   logic        chk_bad;
   logic [15:0] frame_data;

   uart_cmd_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (rx.din_vld),
      .run    (state != ST_IDLE),
      .expire (expire)
   );

   // Final byte of the frame is consumed straight from din, not from a register.
   always_comb begin
`ifdef UART_CMD_CHECKSUM_EN
      frame_end  = rx.din_vld && (state == ST_CHK);
      frame_data = {d1, d0};
      chk_bad    = ((op ^ d1 ^ d0) != rx.din);
`else
      frame_end  = rx.din_vld && (state == ST_D0);
      frame_data = {d1, rx.din};
      chk_bad    = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rx.din_vld && (state == ST_OP)) op <= rx.din;
      if (rx.din_vld && (state == ST_D1)) d1 <= rx.din;
`ifdef UART_CMD_CHECKSUM_EN
      if (rx.din_vld && (state == ST_D0)) d0 <= rx.din;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         thr_hi   <= THR_HI_RST;
         thr_lo   <= THR_LO_RST;
         period   <= PERIOD_RST;
         rpt_en   <= 1'b0;
         cmd_ok   <= 1'b0;
         cmd_err  <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         cmd_ok  <= 1'b0;
         cmd_err <= 1'b0;
         if (frame_end) begin
            state <= ST_IDLE;
            // Checksum is judged before opcode legality.
            if (chk_bad) begin
               cmd_err  <= 1'b1;
               err_code <= ERR_CHECKSUM;
            end else if (!op_legal(op)) begin
               cmd_err  <= 1'b1;
               err_code <= ERR_OPCODE;
            end else begin
               cmd_ok <= 1'b1;
               case (op)
                  OP_THR_HI: thr_hi <= frame_data;
                  OP_THR_LO: thr_lo <= frame_data;
                  OP_PERIOD: period <= frame_data;
                  OP_RPT_EN: rpt_en <= frame_data[0];
                  default:   ;
               endcase
            end
         end else if (rx.din_vld) begin
            case (state)
               ST_IDLE: if (rx.din == HDR_BYTE) state <= ST_OP;
               ST_OP:   state <= ST_D1;
               ST_D1:   state <= ST_D0;
`ifdef UART_CMD_CHECKSUM_EN
               ST_D0:   state <= ST_CHK;
`endif
               default: state <= ST_IDLE;
            endcase
         end else if (expire) begin
            state    <= ST_IDLE;
            cmd_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl with a frame-level reference model; follows
// UART_CMD_CHECKSUM_EN for 4- or 5-byte frames.
module tb_uart_cmd_ctrl;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] thr_hi, thr_lo, period;
   logic        rpt_en, cmd_ok, cmd_err;
   logic [1:0]  err_code;

   uart_cmd_ctrl_if rx ();

   uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .thr_hi   (thr_hi),
      .thr_lo   (thr_lo),
      .period   (period),
      .rpt_en   (rpt_en),
      .cmd_ok   (cmd_ok),
      .cmd_err  (cmd_err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Pulse accounting, sampled away from the active edge.
   int ok_cnt = 0;
   int err_cnt = 0;
   bit both_hi = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_ok)  ok_cnt++;
         if (cmd_err) err_cnt++;
         if (cmd_ok && cmd_err) both_hi = 1'b1;
      end
   end

   // Reference model state: what the configuration registers should hold.
   logic [15:0] m_thr_hi, m_thr_lo, m_period;
   logic        m_rpt_en;
   logic [1:0]  m_code;
   int          exp_ok_n = 0;
   int          exp_err_n = 0;
   logic        exp_ok;
   logic [1:0]  exp_code;
   logic        obs_ok, obs_err;

   task automatic model_reset();
      m_thr_hi = 16'h0320;
      m_thr_lo = 16'h0000;
      m_period = 16'd1000;
      m_rpt_en = 1'b0;
      m_code   = 2'b00;
   endtask

   task automatic model_frame(input logic [7:0] op, d1, d0, chk_xor);
      bit chk_err;
      chk_err  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_err  = (chk_xor != 8'h00);
`endif
      exp_ok   = 1'b1;
      exp_code = m_code;
      if (chk_err) begin
         exp_ok   = 1'b0;
         exp_code = 2'b11;
      end else if (op == 8'h01) m_thr_hi = {d1, d0};
      else if (op == 8'h02) m_thr_lo = {d1, d0};
      else if (op == 8'h03) m_period = {d1, d0};
      else if (op == 8'h04) m_rpt_en = d0[0];
      else begin
         exp_ok   = 1'b0;
         exp_code = 2'b10;
      end
      if (exp_ok) exp_ok_n++;
      else begin
         exp_err_n++;
         m_code = exp_code;
      end
   endtask

   task automatic drive(input logic [7:0] b);
      rx.din     = b;
      rx.din_vld = 1'b1;
      @(negedge clk);
      obs_ok  = cmd_ok;
      obs_err = cmd_err;
   endtask

   task automatic idle(input int n);
      rx.din_vld = 1'b0;
      rx.din     = 8'($urandom);
      repeat (n) @(negedge clk);
   endtask

   // Leaves din_vld high on the final byte so a following frame can start back-to-back.
   task automatic send_frame(input logic [7:0] op, d1, d0, chk_xor, input int gap);
      logic [7:0] bytes[$];
      bytes = '{8'h55, op, d1, d0};
`ifdef UART_CMD_CHECKSUM_EN
      bytes.push_back(op ^ d1 ^ d0 ^ chk_xor);
`endif
      for (int i = 0; i < bytes.size(); i++) begin
         drive(bytes[i]);
         if (i != bytes.size() - 1) idle(gap);
      end
      model_frame(op, d1, d0, chk_xor);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx.din_vld = 1'b0;
      rx.din = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({thr_hi, thr_lo, period, rpt_en} !== {16'h0320, 16'h0000, 16'd1000, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_regs: got %h %h %h %b, required 0320 0000 03e8 0", thr_hi, thr_lo, period, rpt_en);
      end
      vectors++;
      if ({cmd_ok, cmd_err, err_code} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got ok=%b err=%b code=%b, required 0 0 00", cmd_ok, cmd_err, err_code);
      end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_checksum();
      send_frame(8'h01, 8'h00, 8'h10, 8'h11, 0);
      vectors++;
      if (obs_ok !== 1'b0 || obs_err !== 1'b1 || err_code !== 2'b11) begin
         miscompares++;
         $display("FAIL chk_err: got ok=%b err=%b code=%b, required 0 1 11", obs_ok, obs_err, err_code);
      end
      vectors++;
      if (thr_hi !== 16'h0320) begin
         miscompares++;
         $display("FAIL chk_no_update: thr_hi got %h, required 0320", thr_hi);
      end
      idle(2);
   endtask

   task automatic test_thr_hi();
      send_frame(8'h01, 8'h03, 8'h84, 8'h00, 0);
      vectors++;
      if (obs_ok !== 1'b1 || obs_err !== 1'b0) begin
         miscompares++;
         $display("FAIL thr_hi_pulse: got ok=%b err=%b, required 1 0", obs_ok, obs_err);
      end
      vectors++;
      if ({thr_hi, thr_lo, period, rpt_en} !== {16'h0384, m_thr_lo, m_period, m_rpt_en}) begin
         miscompares++;
         $display("FAIL thr_hi_regs: got %h %h %h %b, required 0384 %h %h %b", thr_hi, thr_lo, period, rpt_en, m_thr_lo, m_period, m_rpt_en);
      end
      vectors++;
      if (err_code !== m_code) begin
         miscompares++;
         $display("FAIL err_code_hold: got %b, required %b", err_code, m_code);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      logic r1;
      logic ok1;
      send_frame(8'h04, 8'h00, 8'h01, 8'h00, 0);
      r1  = rpt_en;
      ok1 = obs_ok;
      send_frame(8'h04, 8'h00, 8'h00, 8'h00, 0);
      vectors++;
      if ({r1, ok1, rpt_en, obs_ok} !== 4'b1101) begin
         miscompares++;
         $display("FAIL back_to_back: got rpt_en %b->%b ok %b,%b, required 1->0 ok 1,1", r1, rpt_en, ok1, obs_ok);
      end
      idle(2);
      vectors++;
      if (ok_cnt !== exp_ok_n || err_cnt !== exp_err_n) begin
         miscompares++;
         $display("FAIL b2b_pulses: got ok=%0d err=%0d, required ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok_n, exp_err_n);
      end
   endtask

   task automatic test_garbage();
      drive(8'hAA);
      drive(8'h13);
      send_frame(8'h03, 8'h01, 8'hF4, 8'h00, 0);
      idle(2);
      vectors++;
      if (period !== 16'd500 || ok_cnt !== exp_ok_n || err_cnt !== exp_err_n) begin
         miscompares++;
         $display("FAIL garbage: got period=%0d ok=%0d err=%0d, required 500 %0d %0d", period, ok_cnt, err_cnt, exp_ok_n, exp_err_n);
      end
   endtask

   task automatic test_timeout();
      drive(8'h55);
      drive(8'h02);
      idle(TMO - 1);
      vectors++;
      if (cmd_err !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: cmd_err got %b, required 0", cmd_err);
      end
      idle(1);
      vectors++;
      if (cmd_err !== 1'b1 || cmd_ok !== 1'b0 || err_code !== 2'b01) begin
         miscompares++;
         $display("FAIL timeout: got err=%b ok=%b code=%b, required 1 0 01", cmd_err, cmd_ok, err_code);
      end
      exp_err_n++;
      m_code = 2'b01;
      vectors++;
      if (thr_lo !== m_thr_lo) begin
         miscompares++;
         $display("FAIL timeout_thr_lo: got %h, required %h", thr_lo, m_thr_lo);
      end
      idle(2);
      // Every byte lands on the last cycle before expiry and must be accepted.
      send_frame(8'h02, 8'hBE, 8'hEF, 8'h00, TMO - 1);
      vectors++;
      if (obs_ok !== 1'b1 || thr_lo !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL timeout_edge: got ok=%b thr_lo=%h, required 1 beef", obs_ok, thr_lo);
      end
      idle(2);
      vectors++;
      if (err_cnt !== exp_err_n) begin
         miscompares++;
         $display("FAIL timeout_count: got err pulses %0d, required %0d", err_cnt, exp_err_n);
      end
   endtask

   task automatic test_bad_opcode();
      send_frame(8'h07, 8'h12, 8'h34, 8'h00, 0);
      vectors++;
      if (obs_ok !== 1'b0 || obs_err !== 1'b1 || err_code !== 2'b10) begin
         miscompares++;
         $display("FAIL bad_op: got ok=%b err=%b code=%b, required 0 1 10", obs_ok, obs_err, err_code);
      end
      vectors++;
      if ({thr_hi, thr_lo, period, rpt_en} !== {m_thr_hi, m_thr_lo, m_period, m_rpt_en}) begin
         miscompares++;
         $display("FAIL bad_op_regs: got %h %h %h %b, required %h %h %h %b", thr_hi, thr_lo, period, rpt_en, m_thr_hi, m_thr_lo, m_period, m_rpt_en);
      end
      idle(2);
   endtask

   task automatic test_mid_reset();
      drive(8'h55);
      drive(8'h01);
      idle(1);
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({thr_hi, thr_lo, period, rpt_en, cmd_ok, cmd_err, err_code} !==
          {16'h0320, 16'h0000, 16'd1000, 1'b0, 1'b0, 1'b0, 2'b00}) begin
         miscompares++;
         $display("FAIL mid_reset: got %h %h %h %b ok=%b err=%b code=%b, required reset values", thr_hi, thr_lo, period, rpt_en, cmd_ok, cmd_err, err_code);
      end
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send_frame(8'h01, 8'h0A, 8'hBC, 8'h00, 1);
      vectors++;
      if (obs_ok !== 1'b1 || thr_hi !== 16'h0ABC) begin
         miscompares++;
         $display("FAIL after_reset: got ok=%b thr_hi=%h, required 1 0abc", obs_ok, thr_hi);
      end
      idle(2);
   endtask

   task automatic test_random();
      logic [7:0] op, d1, d0, cx, g;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            g = 8'($urandom);
            if (g == 8'h55) g = 8'h56;
            drive(g);
            idle($urandom_range(0, 2));
         end
         op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
         d1 = 8'($urandom);
         d0 = 8'($urandom);
         cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         send_frame(op, d1, d0, cx, $urandom_range(0, 3));
         vectors++;
         if (obs_ok !== exp_ok || obs_err !== !exp_ok || err_code !== m_code) begin
            miscompares++;
            $display("FAIL rand_frame%0d: got ok=%b err=%b code=%b, required ok=%b code=%b (op=%h)", n, obs_ok, obs_err, err_code, exp_ok, m_code, op);
         end
         vectors++;
         if ({thr_hi, thr_lo, period, rpt_en} !== {m_thr_hi, m_thr_lo, m_period, m_rpt_en}) begin
            miscompares++;
            $display("FAIL rand_regs%0d: got %h %h %h %b, required %h %h %h %b", n, thr_hi, thr_lo, period, rpt_en, m_thr_hi, m_thr_lo, m_period, m_rpt_en);
         end
         idle($urandom_range(0, 3));
      end
      idle(2);
      vectors++;
      if (ok_cnt !== exp_ok_n || err_cnt !== exp_err_n) begin
         miscompares++;
         $display("FAIL rand_pulses: got ok=%0d err=%0d, required ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok_n, exp_err_n);
      end
   endtask

   initial begin
      test_reset();
`ifdef UART_CMD_CHECKSUM_EN
      test_checksum();
`endif
      test_thr_hi();
      test_back_to_back();
      test_garbage();
      test_timeout();
      test_bad_opcode();
      test_mid_reset();
      test_random();
      vectors++;
      if (both_hi !== 1'b0) begin
         miscompares++;
         $display("FAIL ok_err_exclusive: got both high %b, required 0", both_hi);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
